// File: rtl/rat_pc_stack_unit.sv
// rat_pc_stack_unit: RAT MCU program counter with a hardware return stack for CALL/RET and INT/RETI.
// Stack entries are {C, Z, addr}; RETI hands the saved flags back for one cycle.
module rat_pc_stack_unit #(
    parameter int AW = 10,
    parameter int DEPTH = 16,
    parameter logic [AW-1:0] INT_VEC = 'h3FF,
    parameter logic [AW-1:0] RESET_VEC = '0,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int IW = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [2:0]    PC_OP,
    input  logic [AW-1:0] BR_ADDR,
    input  logic          C_IN,
    input  logic          Z_IN,
    input  logic          OVF_CLR,
    output logic [AW-1:0] PC_COUNT,
    output logic [CW-1:0] STK_CNT,
    output logic          STK_FULL,
    output logic          STK_EMPTY,
    output logic          STK_OVF,
    output logic          STK_UNF,
    output logic          FLG_RESTORE,
    output logic          SHAD_C,
    output logic          SHAD_Z
);
    logic [AW-1:0] pc_q, pc_d, pc_inc;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d, unf_q, unf_d, flg_q, flg_d;
    logic          shad_c_q, shad_c_d, shad_z_q, shad_z_d;
    logic [AW+1:0] stk_q [DEPTH];
    logic [AW+1:0] top, push_data;
    logic [IW-1:0] rd_idx, wr_idx;
    logic          full, empty, push;

    assign full   = cnt_q == CW'(DEPTH);
    assign empty  = cnt_q == '0;
    assign pc_inc = pc_q + AW'(1);
    assign rd_idx = IW'(cnt_q - CW'(1));
    assign wr_idx = IW'(cnt_q);
    assign top    = stk_q[rd_idx];

    always_comb begin
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q & ~OVF_CLR;
        unf_d     = unf_q & ~OVF_CLR;
        flg_d     = 1'b0;
        shad_c_d  = shad_c_q;
        shad_z_d  = shad_z_q;
        push      = 1'b0;
        push_data = (PC_OP == 3'd5) ? {C_IN, Z_IN, pc_q} : {2'b00, pc_inc};
        case (PC_OP)
            3'd1: pc_d = pc_inc;
            3'd2: pc_d = BR_ADDR;
            3'd3, 3'd5: begin
                pc_d  = (PC_OP == 3'd5) ? INT_VEC : BR_ADDR;
                push  = ~full;
                cnt_d = full ? cnt_q : cnt_q + CW'(1);
                ovf_d = ovf_d | full;
            end
            3'd4, 3'd6: begin
                // Popping an empty stack degrades to INC so execution keeps moving.
                pc_d  = empty ? pc_inc : top[AW-1:0];
                cnt_d = empty ? cnt_q : cnt_q - CW'(1);
                unf_d = unf_d | empty;
                if (PC_OP == 3'd6 && !empty) begin
                    flg_d    = 1'b1;
                    shad_c_d = top[AW+1];
                    shad_z_d = top[AW];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_q     <= RESET_VEC;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            flg_q    <= 1'b0;
            shad_c_q <= 1'b0;
            shad_z_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            flg_q    <= flg_d;
            shad_c_q <= shad_c_d;
            shad_z_q <= shad_z_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) stk_q[wr_idx] <= push_data;
    end

    assign PC_COUNT    = pc_q;
    assign STK_CNT     = cnt_q;
    assign STK_FULL    = full;
    assign STK_EMPTY   = empty;
    assign STK_OVF     = ovf_q;
    assign STK_UNF     = unf_q;
    assign FLG_RESTORE = flg_q;
    assign SHAD_C      = shad_c_q;
    assign SHAD_Z      = shad_z_q;
endmodule

// File: tb/tb_rat_pc_stack_unit.sv
// tb_rat_pc_stack_unit: directed bench for rat_pc_stack_unit with a LIFO reference model
// feeding a scoreboard of expected post-edge state.
module tb_rat_pc_stack_unit;
    logic       CLK = 1'b0, RST = 1'b1, C_IN = 1'b0, Z_IN = 1'b0, OVF_CLR = 1'b0;
    logic [2:0] PC_OP = 3'd0;
    logic [9:0] BR_ADDR = '0;
    logic [9:0] PC_COUNT;
    logic [4:0] STK_CNT;
    logic       STK_FULL, STK_EMPTY, STK_OVF, STK_UNF, FLG_RESTORE, SHAD_C, SHAD_Z;

    typedef struct {
        logic [9:0] pc;
        logic [4:0] cnt;
        logic       ovf, unf, flg, sc, sz;
    } exp_t;

    exp_t        sb [$];
    logic [11:0] m_stk [$];
    logic [9:0]  m_pc;
    logic        m_ovf, m_unf, m_flg, m_sc, m_sz;
    int          n_assert = 0, n_fail = 0;

    rat_pc_stack_unit dut (
        .CLK(CLK), .RST(RST), .PC_OP(PC_OP), .BR_ADDR(BR_ADDR), .C_IN(C_IN), .Z_IN(Z_IN),
        .OVF_CLR(OVF_CLR), .PC_COUNT(PC_COUNT), .STK_CNT(STK_CNT), .STK_FULL(STK_FULL),
        .STK_EMPTY(STK_EMPTY), .STK_OVF(STK_OVF), .STK_UNF(STK_UNF),
        .FLG_RESTORE(FLG_RESTORE), .SHAD_C(SHAD_C), .SHAD_Z(SHAD_Z)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.pc = m_pc; e.cnt = 5'(m_stk.size()); e.ovf = m_ovf; e.unf = m_unf;
        e.flg = m_flg; e.sc = m_sc; e.sz = m_sz;
        sb.push_back(e);
    endtask

    task automatic compare();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        chk("pc", 32'(PC_COUNT), 32'(e.pc));
        chk("cnt", 32'(STK_CNT), 32'(e.cnt));
        chk("full", 32'(STK_FULL), 32'(e.cnt == 5'd16));
        chk("empty", 32'(STK_EMPTY), 32'(e.cnt == 5'd0));
        chk("ovf", 32'(STK_OVF), 32'(e.ovf));
        chk("unf", 32'(STK_UNF), 32'(e.unf));
        chk("flg_restore", 32'(FLG_RESTORE), 32'(e.flg));
        if (e.flg) begin
            chk("shad_c", 32'(SHAD_C), 32'(e.sc));
            chk("shad_z", 32'(SHAD_Z), 32'(e.sz));
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1; PC_OP = 3'd0; OVF_CLR = 1'b0;
        m_stk.delete();
        m_pc = '0; m_ovf = 0; m_unf = 0; m_flg = 0; m_sc = 0; m_sz = 0;
        push_exp();
        @(posedge CLK); #1;
        compare();
    endtask

    task automatic step(input logic [2:0] o, input logic [9:0] br, input logic c, input logic z,
                        input logic clr);
        logic [11:0] e;
        logic [9:0]  nxt;
        @(negedge CLK);
        RST = 1'b0; PC_OP = o; BR_ADDR = br; C_IN = c; Z_IN = z; OVF_CLR = clr;
        nxt = m_pc + 10'd1;
        m_flg = 1'b0;
        if (clr) begin m_ovf = 1'b0; m_unf = 1'b0; end
        case (o)
            3'd1: m_pc = nxt;
            3'd2: m_pc = br;
            3'd3, 3'd5: begin
                if (m_stk.size() == 16) m_ovf = 1'b1;
                else m_stk.push_back(o == 3'd3 ? {2'b00, nxt} : {c, z, m_pc});
                m_pc = (o == 3'd3) ? br : 10'h3FF;
            end
            3'd4, 3'd6: begin
                if (m_stk.size() == 0) begin
                    m_pc = nxt; m_unf = 1'b1;
                end else begin
                    e = m_stk.pop_back();
                    m_pc = e[9:0];
                    if (o == 3'd6) begin m_flg = 1'b1; m_sc = e[11]; m_sz = e[10]; end
                end
            end
            default: ;
        endcase
        push_exp();
        @(posedge CLK); #1;
        compare();
    endtask

    initial begin
        do_reset();
        chk("reset_pc", 32'(PC_COUNT), 32'h0);
        for (int i = 0; i < 3; i++) step(3'd1, 10'h0, 0, 0, 0);
        chk("inc3_pc", 32'(PC_COUNT), 32'h3);

        step(3'd1, 10'h0, 0, 0, 0);
        step(3'd1, 10'h0, 0, 0, 0);
        step(3'd3, 10'h040, 0, 0, 0);
        chk("call_pc", 32'(PC_COUNT), 32'h40);
        step(3'd0, 10'h155, 1, 1, 0);
        step(3'd7, 10'h2AA, 0, 0, 0);
        step(3'd4, 10'h0, 0, 0, 0);
        chk("ret_pc", 32'(PC_COUNT), 32'h6);

        step(3'd2, 10'h012, 0, 0, 0);
        step(3'd5, 10'h0, 1, 0, 0);
        chk("int_pc", 32'(PC_COUNT), 32'h3FF);
        step(3'd6, 10'h0, 0, 0, 0);
        chk("reti_pc", 32'(PC_COUNT), 32'h12);
        chk("reti_shad_c", 32'(SHAD_C), 32'h1);
        step(3'd1, 10'h0, 0, 0, 0);
        step(3'd5, 10'h0, 0, 1, 0);
        step(3'd6, 10'h0, 0, 0, 0);
        chk("reti_shad_z", 32'(SHAD_Z), 32'h1);

        step(3'd2, 10'h100, 0, 0, 0);
        for (int i = 0; i < 17; i++) step(3'd3, 10'h020, 0, 0, 0);
        chk("ovf_pc", 32'(PC_COUNT), 32'h20);
        step(3'd0, 10'h0, 0, 0, 1);
        step(3'd5, 10'h0, 1, 1, 1);
        chk("ovf_clr_race", 32'(STK_OVF), 32'h1);
        step(3'd2, 10'h020, 0, 0, 1);
        for (int i = 0; i < 16; i++) step(3'd4, 10'h0, 0, 0, 0);
        chk("unwind_pc", 32'(PC_COUNT), 32'h101);

        step(3'd2, 10'h007, 0, 0, 0);
        step(3'd4, 10'h0, 0, 0, 0);
        chk("unf_pc", 32'(PC_COUNT), 32'h8);
        step(3'd4, 10'h0, 0, 0, 1);
        chk("unf_clr_race", 32'(STK_UNF), 32'h1);
        step(3'd0, 10'h0, 0, 0, 1);
        step(3'd6, 10'h0, 1, 1, 0);
        step(3'd0, 10'h0, 0, 0, 1);

        step(3'd2, 10'h3FF, 0, 0, 0);
        step(3'd1, 10'h0, 0, 0, 0);
        chk("wrap_pc", 32'(PC_COUNT), 32'h0);
        step(3'd3, 10'h3FF, 0, 0, 0);
        step(3'd3, 10'h011, 0, 0, 0);
        step(3'd5, 10'h0, 1, 1, 0);
        step(3'd6, 10'h0, 0, 0, 0);
        step(3'd4, 10'h0, 0, 0, 0);
        step(3'd3, 10'h055, 0, 0, 0);
        step(3'd3, 10'h066, 0, 0, 0);
        do_reset();
        chk("rst_cnt", 32'(STK_CNT), 32'h0);
        step(3'd4, 10'h0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
